// File: rtl/uart_word_tx.sv
// uart_word_tx: serialises one DATA_W-bit word as back-to-back 8N1/8N2 UART frames.
// Define UART_PARITY_EN to insert an even-parity bit after each byte's data bits.
module uart_word_tx #(
  parameter int CLK_F     = 50_000_000,
  parameter int UART_BPS  = 115200,
  parameter int DATA_W    = 64,
  parameter int STOP_BITS = 1,
  parameter int MSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              uart_txd,
  output logic              busy,
  output logic              data_done
);

  localparam int CLK_GOAL = CLK_F / UART_BPS;
  localparam int NBYTES   = DATA_W / 8;
  localparam int TMR_W    = (CLK_GOAL > 1) ? $clog2(CLK_GOAL) : 1;
  localparam int BYTE_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t              state_reg, state_next;
  logic [TMR_W-1:0]    timer_reg, timer_next;
  logic [2:0]          bit_idx_reg, bit_idx_next;
  logic [BYTE_W-1:0]   byte_idx_reg, byte_idx_next;
  logic                stop_idx_reg, stop_idx_next;
  logic [DATA_W-1:0]   shift_reg, shift_next;
  logic                done_reg, done_next;
  logic [7:0]          cur_byte;
  logic [DATA_W-1:0]   shift_adv;
  logic                bit_end;

  // The byte on the wire always sits at the outgoing end of the shift register.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign cur_byte  = shift_reg[DATA_W-1 -: 8];
      assign shift_adv = shift_reg << 8;
    end else begin : g_lsb
      assign cur_byte  = shift_reg[7:0];
      assign shift_adv = shift_reg >> 8;
    end
  endgenerate

  assign bit_end = (timer_reg == TMR_W'(CLK_GOAL - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      timer_reg    <= '0;
      bit_idx_reg  <= '0;
      byte_idx_reg <= '0;
      stop_idx_reg <= 1'b0;
      shift_reg    <= '0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      timer_reg    <= timer_next;
      bit_idx_reg  <= bit_idx_next;
      byte_idx_reg <= byte_idx_next;
      stop_idx_reg <= stop_idx_next;
      shift_reg    <= shift_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    bit_idx_next  = bit_idx_reg;
    byte_idx_next = byte_idx_reg;
    stop_idx_next = stop_idx_reg;
    shift_next    = shift_reg;
    done_next     = 1'b0;

    if (state_reg != S_IDLE) begin
      timer_next = bit_end ? '0 : timer_reg + TMR_W'(1);
    end

    case (state_reg)
      S_IDLE: begin
        if (data_valid) begin
          state_next    = S_START;
          shift_next    = data_in;
          byte_idx_next = '0;
          timer_next    = '0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_next   = S_DATA;
          bit_idx_next = '0;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx_reg == 3'd7) begin
`ifdef UART_PARITY_EN
            state_next    = S_PARITY;
`else
            state_next    = S_STOP;
`endif
            stop_idx_next = 1'b0;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_next    = S_STOP;
          stop_idx_next = 1'b0;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (stop_idx_reg == 1'(STOP_BITS - 1)) begin
            // Last stop period of this byte: either chain the next frame or finish the word.
            if (byte_idx_reg == BYTE_W'(NBYTES - 1)) begin
              state_next = S_IDLE;
              done_next  = 1'b1;
            end else begin
              state_next    = S_START;
              byte_idx_next = byte_idx_reg + BYTE_W'(1);
              shift_next    = shift_adv;
            end
          end else begin
            stop_idx_next = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    uart_txd = 1'b1;
    case (state_reg)
      S_START:  uart_txd = 1'b0;
      S_DATA:   uart_txd = cur_byte[bit_idx_reg];
`ifdef UART_PARITY_EN
      S_PARITY: uart_txd = ^cur_byte;
`endif
      default:  uart_txd = 1'b1;
    endcase
  end

  assign data_ready = (state_reg == S_IDLE);
  assign busy       = (state_reg != S_IDLE);
  assign data_done  = done_reg;

endmodule

// File: tb/tb_uart_word_tx.sv
// Self-checking bench for uart_word_tx: three instances (40 MHz/115200 64-bit, fast 64-bit, fast 16-bit MSB-first 2-stop).
// Expected line waveforms come from a frame-list model built from the word bytes.
module tb_uart_word_tx;

`ifdef UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int CG_A = 40_000_000 / 115200;
  localparam int CG_B = 1_000_000 / 200_000;

  logic        clk = 1'b0;
  logic [2:0]  rst_w = 3'b111;
  logic [2:0]  valid_w = 3'b000;
  logic [2:0]  ready_w, txd_w, busy_w, done_w;
  logic [63:0] data_a = '0, data_b = '0;
  logic [15:0] data_c = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_word_tx #(.CLK_F(40_000_000), .UART_BPS(115200), .DATA_W(64), .STOP_BITS(1), .MSB_FIRST(0)) dut_a (
    .clk(clk), .rst(rst_w[0]), .data_in(data_a), .data_valid(valid_w[0]), .data_ready(ready_w[0]),
    .uart_txd(txd_w[0]), .busy(busy_w[0]), .data_done(done_w[0]));

  uart_word_tx #(.CLK_F(1_000_000), .UART_BPS(200_000), .DATA_W(64), .STOP_BITS(1), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst(rst_w[1]), .data_in(data_b), .data_valid(valid_w[1]), .data_ready(ready_w[1]),
    .uart_txd(txd_w[1]), .busy(busy_w[1]), .data_done(done_w[1]));

  uart_word_tx #(.CLK_F(1_000_000), .UART_BPS(200_000), .DATA_W(16), .STOP_BITS(2), .MSB_FIRST(1)) dut_c (
    .clk(clk), .rst(rst_w[2]), .data_in(data_c), .data_valid(valid_w[2]), .data_ready(ready_w[2]),
    .uart_txd(txd_w[2]), .busy(busy_w[2]), .data_done(done_w[2]));

  function automatic int cg_of(input int id);  return (id == 0) ? CG_A : CG_B; endfunction
  function automatic int nb_of(input int id);  return (id == 2) ? 2 : 8;       endfunction
  function automatic bit msb_of(input int id); return (id == 2);               endfunction
  function automatic int sb_of(input int id);  return (id == 2) ? 2 : 1;       endfunction

  function automatic logic [7:0] exp_byte(input int id, input logic [63:0] w, input int b);
    int bi;
    bi = msb_of(id) ? nb_of(id) - 1 - b : b;
    return w[bi*8 +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_data(input int id, input logic [63:0] v);
    case (id)
      0:       data_a = v;
      1:       data_b = v;
      default: data_c = v[15:0];
    endcase
  endtask

  // Reference: the word as a list of bit periods (start, 8 data LSB first, [even parity], stops).
  task automatic build_line(input int id, input logic [63:0] w, output bit q[$]);
    logic [7:0] by;
    q = {};
    for (int b = 0; b < nb_of(id); b++) begin
      by = exp_byte(id, w, b);
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(by[i]);
      if (P != 0) q.push_back(^by);
      for (int s = 0; s < sb_of(id); s++) q.push_back(1'b1);
    end
  endtask

  task automatic accept(input int id, input logic [63:0] w);
    check(ready_w[id] === 1'b1, $sformatf("ready_idle id%0d", id), 64'(ready_w[id]), 64'd1);
    set_data(id, w);
    valid_w[id] = 1'b1;
    tick();
    valid_w[id] = 1'b0;
    set_data(id, {$urandom, $urandom});
  endtask

  // Entered in the start-bit cycle; returns in the data_done cycle (or early at stop_at).
  // mode 0: quiet, 1: junk valid pulse mid-word, 2: next word offered from mid-word on.
  task automatic stream(input int id, input logic [63:0] w, input int mode, input logic [63:0] nxt,
                        input int stop_at, output logic [7:0] rx[$]);
    bit q[$];
    int cg, fl, total, t, pos;
    bit ok;
    logic [7:0] by;
    logic [3:0] act;
    build_line(id, w, q);
    cg = cg_of(id);
    fl = 9 + P + sb_of(id);
    total = q.size() * cg;
    rx = {};
    by = '0;
    act = '0;
    for (int k = 0; k < q.size(); k++) begin
      ok = 1'b1;
      pos = k % fl;
      for (int c = 0; c < cg; c++) begin
        t = k * cg + c;
        if (stop_at >= 0 && t == stop_at) return;
        if (mode == 1 && t == total / 2) begin valid_w[id] = 1'b1; set_data(id, '0); end
        if (mode == 1 && t == total / 2 + 2 * cg) valid_w[id] = 1'b0;
        if (mode == 2 && t == total / 2) begin valid_w[id] = 1'b1; set_data(id, nxt); end
        if (ok && (txd_w[id] !== q[k] || busy_w[id] !== 1'b1 || ready_w[id] !== 1'b0 || done_w[id] !== 1'b0)) begin
          ok = 1'b0;
          act = {txd_w[id], busy_w[id], ready_w[id], done_w[id]};
        end
        if (c == cg / 2 && pos >= 1 && pos <= 8) by[pos-1] = txd_w[id];
        tick();
      end
      if (pos == 8) rx.push_back(by);
      check(ok, $sformatf("bit id%0d k%0d {txd,busy,ready,done}", id, k), 64'(act), 64'({q[k], 3'b100}));
    end
    act = {txd_w[id], busy_w[id], ready_w[id], done_w[id]};
    check(act === 4'b1011, $sformatf("done id%0d {txd,busy,ready,done}", id), 64'(act), 64'(4'b1011));
  endtask

  task automatic check_rx(input int id, input logic [63:0] w, input logic [7:0] rx[$]);
    bit ok;
    ok = (rx.size() == nb_of(id));
    for (int b = 0; b < rx.size() && ok; b++) if (rx[b] !== exp_byte(id, w, b)) ok = 1'b0;
    check(ok, $sformatf("rx id%0d bytes", id), (rx.size() > 0) ? 64'(rx[0]) : 64'hdead, 64'(exp_byte(id, w, 0)));
    $display("[TB] word id=%0d data=%h bytes=%0d", id, w, rx.size());
  endtask

  task automatic idle_check(input int id, input int n);
    bit ok;
    logic [3:0] act;
    ok = 1'b1;
    act = 4'b1010;
    for (int c = 0; c < n; c++) begin
      if (ok && {txd_w[id], busy_w[id], ready_w[id], done_w[id]} !== 4'b1010) begin
        ok = 1'b0;
        act = {txd_w[id], busy_w[id], ready_w[id], done_w[id]};
      end
      tick();
    end
    check(ok, $sformatf("idle id%0d {txd,busy,ready,done}", id), 64'(act), 64'(4'b1010));
  endtask

  typedef struct {
    int          id;
    logic [63:0] word;
    logic [7:0]  first;
    logic [7:0]  last;
  } vec_t;

  initial begin
    vec_t tbl[5];
    logic [7:0] rx[$];
    logic [63:0] cur, nxt, w1;
    bit pend;
    int mode, fl;

    tbl[0] = '{0, 64'h9cddb2b4c4311de1, 8'he1, 8'h9c};
    tbl[1] = '{1, 64'h33e22893d059fe6f, 8'h6f, 8'h33};
    tbl[2] = '{2, 64'h000000000000a55a, 8'ha5, 8'h5a};
    tbl[3] = '{1, 64'h00000000000000ff, 8'hff, 8'h00};
    tbl[4] = '{2, 64'h0000000000000180, 8'h01, 8'h80};

    tick();
    tick();
    for (int id = 0; id < 3; id++)
      check({txd_w[id], busy_w[id], ready_w[id], done_w[id]} === 4'b1010,
            $sformatf("reset id%0d {txd,busy,ready,done}", id),
            64'({txd_w[id], busy_w[id], ready_w[id], done_w[id]}), 64'(4'b1010));
    rst_w = 3'b000;
    tick();

    // Table: each vector sent alone, line decoded and first/last bytes compared.
    for (int i = 0; i < 5; i++) begin
      accept(tbl[i].id, tbl[i].word);
      stream(tbl[i].id, tbl[i].word, 0, '0, -1, rx);
      tick();
      check(rx.size() > 0 && rx[0] === tbl[i].first, $sformatf("tbl%0d first byte", i),
            (rx.size() > 0) ? 64'(rx[0]) : 64'hdead, 64'(tbl[i].first));
      check(rx.size() > 0 && rx[rx.size()-1] === tbl[i].last, $sformatf("tbl%0d last byte", i),
            (rx.size() > 0) ? 64'(rx[rx.size()-1]) : 64'hdead, 64'(tbl[i].last));
      $display("[TB] table %0d id=%0d data=%h", i, tbl[i].id, tbl[i].word);
      idle_check(tbl[i].id, 4);
    end

    // Back-to-back: next word held valid during word 1, accepted in the done cycle.
    w1 = 64'h9cddb2b4c4311de1;
    accept(1, w1);
    stream(1, w1, 2, 64'h33e22893d059fe6f, -1, rx);
    check_rx(1, w1, rx);
    tick();
    valid_w[1] = 1'b0;
    stream(1, 64'h33e22893d059fe6f, 0, '0, -1, rx);
    check_rx(1, 64'h33e22893d059fe6f, rx);
    tick();
    idle_check(1, 4);

    // Junk valid pulse while busy is ignored.
    accept(1, w1);
    stream(1, w1, 1, '0, -1, rx);
    check_rx(1, w1, rx);
    tick();
    idle_check(1, 6);

    // Reset during the third byte, then a clean word.
    fl = 10 + P;
    accept(1, w1);
    stream(1, w1, 0, '0, 2 * fl * CG_B + 4 * CG_B, rx);
    rst_w[1] = 1'b1;
    tick();
    rst_w[1] = 1'b0;
    check({txd_w[1], busy_w[1], ready_w[1], done_w[1]} === 4'b1010, "mid-word reset {txd,busy,ready,done}",
          64'({txd_w[1], busy_w[1], ready_w[1], done_w[1]}), 64'(4'b1010));
    idle_check(1, 12 * CG_B);
    accept(1, 64'h1c1624f290daa4cb);
    stream(1, 64'h1c1624f290daa4cb, 0, '0, -1, rx);
    check_rx(1, 64'h1c1624f290daa4cb, rx);
    tick();
    idle_check(1, 4);

    // Randomised words with random chaining / junk pulses.
    pend = 1'b0;
    cur = '0;
    for (int i = 0; i < 12; i++) begin
      if (!pend) begin
        cur = {$urandom, $urandom};
        accept(1, cur);
      end
      mode = $urandom_range(0, 2);
      if (i == 11 && mode == 2) mode = 0;
      nxt = {$urandom, $urandom};
      stream(1, cur, mode, nxt, -1, rx);
      check_rx(1, cur, rx);
      tick();
      if (mode == 2) begin
        valid_w[1] = 1'b0;
        cur = nxt;
        pend = 1'b1;
      end else begin
        pend = 1'b0;
        idle_check(1, 3);
      end
    end

    // 16-bit MSB-first two-stop-bit word through the random path too.
    cur = {48'h0, 16'($urandom)};
    accept(2, cur);
    stream(2, cur, 0, '0, -1, rx);
    check_rx(2, cur, rx);
    tick();
    idle_check(2, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
